// File: rtl/dice_result_capture_if.sv
// -----------------------------------------------------------------------------
// dice_result_capture_if
// Groups the signals exchanged between the dice result capture block and its
// surroundings (roll button, dice face, display/status outputs, histogram).
//
// Parameters:
//   CNT_W        width of the histogram read-back bus
// Signals:
//   button       roll button, already synchronised
//   throw        dice face from the dice counter (legal 1..6)
//   rolling      high while the button is held or the face is settling
//   result       last captured legal face, 0 = none yet
//   result_valid one-cycle strobe when result updates
//   pips         7-LED pattern [6]TL [5]TR [4]ML [3]C [2]MR [1]BL [0]BR
//   error        sticky illegal-sample flag
//   hist_sel     histogram face select
//   hist_count   roll count for face hist_sel
// Modports:
//   master       drives button/throw/hist_sel, observes the results
//   slave        the capture block itself
// -----------------------------------------------------------------------------
interface dice_result_capture_if #(
  parameter int CNT_W = 8
);
  logic             button;
  logic [2:0]       throw;
  logic             rolling;
  logic [2:0]       result;
  logic             result_valid;
  logic [6:0]       pips;
  logic             error;
  logic [2:0]       hist_sel;
  logic [CNT_W-1:0] hist_count;

  modport master (
    output button, throw, hist_sel,
    input  rolling, result, result_valid, pips, error, hist_count
  );

  modport slave (
    input  button, throw, hist_sel,
    output rolling, result, result_valid, pips, error, hist_count
  );
endinterface

// File: rtl/dice_result_capture.sv
// -----------------------------------------------------------------------------
// dice_result_capture
// Consumer end of the electronic dice. Watches the roll button, waits for the
// dice to settle after release, samples and validates the face, and publishes
// it as a registered result, a one-cycle valid strobe and an LED pip pattern.
//
// Parameters:
//   SETTLE_CYCLES  cycles after the first low button cycle before throw is
//                  sampled (>= 1)
//   CNT_W          width of the per-face roll counters (saturating)
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   bus            dice_result_capture_if.slave (button, throw, rolling,
//                  result, result_valid, pips, error, hist_sel, hist_count)
// Configuration:
//   DICE_HIST_EN   when defined, six saturating per-face roll counters are
//                  built and readable through hist_sel/hist_count; otherwise
//                  hist_count reads 0 and hist_sel is ignored.
// -----------------------------------------------------------------------------
module dice_result_capture #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  dice_result_capture_if.slave   bus
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLLING = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_SHOW    = 2'd3
  } state_e;

  // Face value to LED pattern; illegal faces light nothing.
  function automatic logic [6:0] pip_decode(input logic [2:0] face);
    logic [6:0] p;
    case (face)
      3'd1:    p = 7'h08;
      3'd2:    p = 7'h41;
      3'd3:    p = 7'h49;
      3'd4:    p = 7'h63;
      3'd5:    p = 7'h6B;
      3'd6:    p = 7'h77;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  function automatic logic face_legal(input logic [2:0] face);
    return (face != 3'd0) && (face != 3'd7);
  endfunction

  state_e           state_q,        state_d;
  logic [SET_W-1:0] settle_cnt_q,   settle_cnt_d;
  logic [2:0]       result_q,       result_d;
  logic             result_valid_q, result_valid_d;
  logic [6:0]       pips_q,         pips_d;
  logic             rolling_q,      rolling_d;
  logic             error_q,        error_d;

  // Next-state and next-output computation for the capture FSM.
  always_comb begin
    state_d        = state_q;
    settle_cnt_d   = settle_cnt_q;
    result_d       = result_q;
    error_d        = error_q;
    result_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.button) begin
          state_d = ST_ROLLING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROLLING: begin
        if (!bus.button) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = SETTLE_LOAD;
        end else begin
          state_d = ST_ROLLING;
        end
      end
      ST_SETTLE: begin
        // A re-press wins over a sample due in the same cycle.
        if (bus.button) begin
          state_d = ST_ROLLING;
        end else if (settle_cnt_q == {SET_W{1'b0}}) begin
          if (face_legal(bus.throw)) begin
            state_d        = ST_SHOW;
            result_d       = bus.throw;
            error_d        = 1'b0;
            result_valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            error_d = 1'b1;
          end
        end else begin
          settle_cnt_d = settle_cnt_q - SET_W'(1);
        end
      end
      ST_SHOW: begin
        if (bus.button) begin
          state_d = ST_ROLLING;
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so that, once registered, they
    // line up exactly with the state they describe.
    rolling_d = (state_d == ST_ROLLING) || (state_d == ST_SETTLE);
    if (rolling_d) begin
      pips_d = 7'h00;
    end else begin
      pips_d = pip_decode(result_d);
    end
  end

  // State, settle counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      settle_cnt_q   <= {SET_W{1'b0}};
      result_q       <= 3'd0;
      result_valid_q <= 1'b0;
      pips_q         <= 7'h00;
      rolling_q      <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      pips_q         <= pips_d;
      rolling_q      <= rolling_d;
      error_q        <= error_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.pips         = pips_q;
  assign bus.rolling      = rolling_q;
  assign bus.error        = error_q;

`ifdef DICE_HIST_EN
  logic [CNT_W-1:0] hist_q [6];
  logic [CNT_W-1:0] hist_d [6];
  logic [CNT_W-1:0] hist_count_s;

  // Bump the counter of the face being captured, holding at all-ones.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      if (result_valid_d && (result_d == 3'(i + 1)) && (hist_q[i] != {CNT_W{1'b1}})) begin
        hist_d[i] = hist_q[i] + CNT_W'(1);
      end else begin
        hist_d[i] = hist_q[i];
      end
    end
  end

  // Per-face roll counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        hist_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  // Combinational histogram read port; faces 0 and 7 have no counter.
  always_comb begin
    case (bus.hist_sel)
      3'd1:    hist_count_s = hist_q[0];
      3'd2:    hist_count_s = hist_q[1];
      3'd3:    hist_count_s = hist_q[2];
      3'd4:    hist_count_s = hist_q[3];
      3'd5:    hist_count_s = hist_q[4];
      3'd6:    hist_count_s = hist_q[5];
      default: hist_count_s = {CNT_W{1'b0}};
    endcase
  end

  assign bus.hist_count = hist_count_s;
`else
  assign bus.hist_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dice_result_capture.sv
// -----------------------------------------------------------------------------
// tb_dice_result_capture
// Directed bench for dice_result_capture. Stimulus pushes the expected
// capture (face, pips, cycle of the valid strobe) into a queue; a monitor
// pops and compares on every result_valid strobe. Status outputs are checked
// directly by the stimulus at chosen points.
// -----------------------------------------------------------------------------
module tb_dice_result_capture;

  localparam int S = 2;
`ifdef DICE_HIST_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  typedef struct {
    logic [2:0] res;
    logic [6:0] pips;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t exp_q [$];

  dice_result_capture_if #(.CNT_W(CNT_W)) bus ();

  dice_result_capture #(
    .SETTLE_CYCLES (S),
    .CNT_W         (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid strobe must match the oldest expected capture.
  always @(negedge clk) begin
    exp_t e;
    if (bus.result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_valid: got result %0h with no capture expected (cycle %0d)",
                 bus.result, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("valid_result", 32'(bus.result), 32'(e.res));
        chk("valid_pips",   32'(bus.pips),   32'(e.pips));
        chk("valid_cycle",  32'(cyc),        32'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the button for 'hold' cycles, release with 'face', wait for the sample.
  task automatic roll(input int hold, input logic [2:0] face, input logic legal,
                      input logic [6:0] exp_pips);
    exp_t e;
    bus.button = 1'b1;
    tick(hold);
    chk("hold_rolling", 32'(bus.rolling), 32'd1);
    chk("hold_pips",    32'(bus.pips),    32'd0);
    bus.throw  = face;
    bus.button = 1'b0;
    if (legal) begin
      e.res  = face;
      e.pips = exp_pips;
      e.cyc  = cyc + S + 1;
      exp_q.push_back(e);
    end
    tick(S + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   wait_cnt;

    // Reset with button held and a legal face present.
    bus.button   = 1'b1;
    bus.throw    = 3'd5;
    bus.hist_sel = 3'd2;
    rst          = 1'b1;
    tick(2);
    chk("rst_result",  32'(bus.result),  32'd0);
    chk("rst_pips",    32'(bus.pips),    32'd0);
    chk("rst_rolling", 32'(bus.rolling), 32'd0);
    chk("rst_error",   32'(bus.error),   32'd0);
    chk("rst_hist",    32'(bus.hist_count), 32'd0);
    bus.button = 1'b0;
    rst        = 1'b0;
    tick(2);

    // Basic roll.
    roll(4, 3'd3, 1'b1, 7'h49);
    chk("basic_result",  32'(bus.result),  32'd3);
    chk("basic_pips",    32'(bus.pips),    32'h49);
    chk("basic_rolling", 32'(bus.rolling), 32'd0);
    chk("basic_error",   32'(bus.error),   32'd0);

    // Re-press during settle: no sample may be taken.
    bus.throw  = 3'd1;
    bus.button = 1'b1;
    tick(3);
    bus.button = 1'b0;
    tick(1);
    bus.button = 1'b1;
    tick(4);
    chk("repress_rolling", 32'(bus.rolling), 32'd1);
    chk("repress_result",  32'(bus.result),  32'd3);
    chk("repress_pips",    32'(bus.pips),    32'd0);

    // Illegal face 7: error, result kept, back to IDLE showing the old face.
    roll(2, 3'd7, 1'b0, 7'h00);
    chk("ill7_error",   32'(bus.error),   32'd1);
    chk("ill7_result",  32'(bus.result),  32'd3);
    chk("ill7_rolling", 32'(bus.rolling), 32'd0);
    chk("ill7_pips",    32'(bus.pips),    32'h49);

    // Next legal capture clears the error.
    roll(3, 3'd6, 1'b1, 7'h77);
    chk("six_error",  32'(bus.error),  32'd0);
    chk("six_result", 32'(bus.result), 32'd6);
    chk("six_pips",   32'(bus.pips),   32'h77);

    // New roll from SHOW blanks the display on the next cycle.
    roll(2, 3'd4, 1'b1, 7'h63);
    chk("four_pips", 32'(bus.pips), 32'h63);
    bus.button = 1'b1;
    tick(1);
    chk("newroll_pips",    32'(bus.pips),    32'd0);
    chk("newroll_rolling", 32'(bus.rolling), 32'd1);

    // Reset just before the sample is due: roll aborted, no strobe.
    tick(1);
    bus.button = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_result",  32'(bus.result),  32'd0);
    chk("abort_rolling", 32'(bus.rolling), 32'd0);
    chk("abort_pips",    32'(bus.pips),    32'd0);
    tick(4);

    // Illegal face 0 before any capture.
    roll(2, 3'd0, 1'b0, 7'h00);
    chk("ill0_error",  32'(bus.error),  32'd1);
    chk("ill0_result", 32'(bus.result), 32'd0);
    chk("ill0_pips",   32'(bus.pips),   32'd0);

    // Face changes while settling: only the value at the sample edge counts.
    bus.button = 1'b1;
    tick(2);
    bus.throw  = 3'd7;
    bus.button = 1'b0;
    e.res  = 3'd5;
    e.pips = 7'h6B;
    e.cyc  = cyc + S + 1;
    exp_q.push_back(e);
    tick(1);
    bus.throw = 3'd5;
    tick(S + 1);
    chk("late_result", 32'(bus.result), 32'd5);
    chk("late_error",  32'(bus.error),  32'd0);

`ifdef DICE_HIST_EN
    // Five captures of face 2 saturate a 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      roll(2, 3'd2, 1'b1, 7'h41);
    end
    bus.hist_sel = 3'd2;
    #1;
    chk("hist_face2_sat", 32'(bus.hist_count), 32'd3);
    bus.hist_sel = 3'd5;
    #1;
    chk("hist_face5", 32'(bus.hist_count), 32'd1);
    bus.hist_sel = 3'd1;
    #1;
    chk("hist_face1", 32'(bus.hist_count), 32'd0);
    bus.hist_sel = 3'd7;
    #1;
    chk("hist_sel7", 32'(bus.hist_count), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.hist_sel = 3'd2;
    #1;
    chk("hist_after_rst", 32'(bus.hist_count), 32'd0);
`else
    roll(2, 3'd2, 1'b1, 7'h41);
    bus.hist_sel = 3'd2;
    #1;
    chk("hist_disabled", 32'(bus.hist_count), 32'd0);
`endif

    // Drain: every expected capture must have been strobed.
    wait_cnt = 0;
    while ((exp_q.size() != 0) && (wait_cnt < 20)) begin
      tick(1);
      wait_cnt++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL missing_valid: got %0d captures outstanding expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dice_result_capture.md
Name: dice_result_capture

Overview:
- Consumer end of the electronic dice interface: watches the same `button` line the dice sees, plus the dice's 3-bit `throw` output.
- On button release, waits for the dice to settle, then samples and validates the face.
- Publishes the captured face as a registered value, a one-cycle valid strobe and a 7-LED pip pattern for the board display.
- Sits between the dice counter and the LED/display driver.

Parameters:
- SETTLE_CYCLES, 2, cycles after button falling edge before `throw` is sampled (must be >=1).
- CNT_W, 8, width of per-face roll counters; counters saturate at all-ones.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- button  input  1  roll button, same signal driven into the dice; already synchronised
- throw  input  3  dice face output; legal 1..6; 0 and 7 illegal
- rolling  output  1  high while button held or settling
- result  output  3  last captured legal face; 0 = none yet
- result_valid  output  1  one-cycle pulse when `result` updates
- pips  output  7  LED pattern: [6]TL [5]TR [4]ML [3]C [2]MR [1]BL [0]BR
- error  output  1  sticky; set when a sample is illegal, cleared by rst or next legal capture
- hist_sel  input  3  face select for histogram read (DICE_HIST_EN only)
- hist_count  output  CNT_W  roll count for face `hist_sel` (DICE_HIST_EN only)

Behaviour:
- Reset:
  - State IDLE.
  - `result` = 0, `result_valid` = 0, `pips` = 7'h00, `rolling` = 0, `error` = 0.
  - Settle counter = 0; histogram counters = 0.
  - Reset asserted in any state aborts the roll; no valid pulse is issued.
- FSM states: IDLE, ROLLING, SETTLE, SHOW.
  - IDLE: `button`=1 -> ROLLING.
  - ROLLING: `rolling`=1, `pips`=0. `button`=0 -> SETTLE and load settle counter with SETTLE_CYCLES-1.
  - SETTLE: `rolling`=1, `pips`=0.
    - `button`=1 -> ROLLING (re-press aborts the capture, no sample taken).
    - Counter 0 -> sample `throw` this cycle. Legal -> SHOW. Illegal -> IDLE.
    - Otherwise decrement the counter.
- Capture timing: sample occurs in the SETTLE_CYCLES-th cycle after the first cycle `button` is seen low.
  - Legal sample: `result` <= throw, `error` <= 0, and `result_valid` is high for exactly the next cycle, which is the first cycle in SHOW.
  - Illegal sample (0 or 7): `result` unchanged, `result_valid` stays 0, `error` <= 1.
- SHOW: `rolling`=0; `pips` = decode(`result`); held indefinitely. `button`=1 -> ROLLING, and `pips` blank from the next cycle.
- IDLE: `pips` = decode(`result`), i.e. 0 before the first capture.
- Pip decode: 1->7'h08, 2->7'h41, 3->7'h49, 4->7'h63, 5->7'h6B, 6->7'h77, 0/7->7'h00.
- All outputs are registered; no combinational path from inputs to outputs except `hist_count` from `hist_sel`.

Optional Feature:
- Macro DICE_HIST_EN.
- Defined:
  - Six CNT_W-bit counters, one per face.
  - On each legal capture, the counter for that face increments, saturating at 2^CNT_W-1.
  - `hist_count` = counter[`hist_sel`] combinationally; `hist_sel` 0 or 7 reads 0.
- Undefined:
  - No counters are instantiated.
  - `hist_count` is tied to 0; `hist_sel` is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles with button=1, throw=5 -> `result`=0, `pips`=0, `rolling`=0, `error`=0, no `result_valid`.
- Basic roll: button high 4 cycles, then low with throw=3 held -> valid pulse exactly SETTLE_CYCLES+1 cycles after the first low cycle; `result`=3, `pips`=7'h49 in SHOW.
- Re-press in SETTLE: button low 1 cycle, then high again -> back to ROLLING, no valid pulse, `result` keeps previous value.
- Illegal face: release with throw=7 -> `error`=1, no pulse, `result` unchanged, state IDLE. Next release with throw=6 -> `error`=0, `result`=6, `pips`=7'h77.
- New roll from SHOW: result=4 displayed (7'h63); button=1 -> `pips`=0 and `rolling`=1 the next cycle.
- DICE_HIST_EN with CNT_W=2: five captures of face 2 -> `hist_count` with hist_sel=2 reads 3 (saturated); hist_sel=1 reads 0; rst clears it to 0.
